// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared types and helpers for the add arbiter
package add_arb_pkg;

  typedef enum logic {EMPTY, FULL} add_arb_state_t;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// rtl/add_arbiter_if.sv - request/response bus between clients and the add arbiter
interface add_arbiter_if
  import add_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_ovf;

  // Client side: presents operands and consumes responses
  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
  );

endinterface

// File: rtl/add.sv
// rtl/add.sv - shared WIDTH-bit unsigned adder datapath
module add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one adder; ADD_ARB_SAT_EN selects saturating sum
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_arbiter_if.slave  bus
);

  localparam int IDW = id_width(NREQ);

  add_arb_state_t   state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   next_ptr;
  logic             grant_found;
  logic             slot_free;
  logic             accept;
  logic [NREQ-1:0]  ready_vec;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] next_sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic [IDW-1:0]   id_q;
  logic             ovf_q;
  int               idx;

  // The slot can take a new result when empty or when it drains this cycle
  assign slot_free = (state == EMPTY) || bus.rsp_ready;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && bus.req_valid[IDW'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  assign accept   = slot_free && grant_found;
  assign next_ptr = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  // One-hot ready for the granted requester; forced low while in reset
  always_comb begin
    ready_vec = '0;
    if (accept) ready_vec[grant_id] = 1'b1;
  end

  assign bus.req_ready = rst_n ? ready_vec : '0;

  assign op_a = bus.req_in1[grant_id*WIDTH +: WIDTH];
  assign op_b = bus.req_in2[grant_id*WIDTH +: WIDTH];

  add #(.WIDTH(WIDTH)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  // Carry taken from a zero-extended WIDTH+1 bit sum
  assign carry = 1'(({1'b0, op_a} + {1'b0, op_b}) >> WIDTH);

`ifdef ADD_ARB_SAT_EN
  assign next_sum = carry ? {WIDTH{1'b1}} : add_sum;
`else
  assign next_sum = add_sum;
`endif

  // Response slot FSM: EMPTY/FULL with registered result, id and overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rr_ptr <= '0;
      sum_q  <= '0;
      id_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= FULL;
            sum_q  <= next_sum;
            id_q   <= grant_id;
            ovf_q  <= carry;
            rr_ptr <= next_ptr;
          end
        end
        FULL: begin
          if (accept) begin
            sum_q  <= next_sum;
            id_q   <= grant_id;
            ovf_q  <= carry;
            rr_ptr <= next_ptr;
          end else if (bus.rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - scoreboard bench for add_arbiter
module tb_add_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  typedef struct {
    logic [31:0] sum;
    logic [1:0]  id;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t q[$];
  exp_t e;

  add_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_in1[i*WIDTH +: WIDTH] = a;
    bus.req_in2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push(input logic [31:0] s, input logic [1:0] id, input logic ovf);
    exp_t x;
    x.sum = s;
    x.id  = id;
    x.ovf = ovf;
    q.push_back(x);
  endtask

  // Monitor: every completed response handshake is compared against the queue head
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d sum %0h expected no response", bus.rsp_id, bus.rsp_sum);
      end else begin
        e = q.pop_front();
        chk("rsp_sum", bus.rsp_sum, e.sum);
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_ovf", 32'(bus.rsp_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i * 16 + 1), 32'h100);

    // Reset with all requests valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_sum", bus.rsp_sum, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin with all requesters valid, no bubbles
    for (int k = 0; k < 8; k++) push(32'h101 + 32'((k % 4) * 16), 2'(k % 4), 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_req_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_no_bubble", 32'(bus.rsp_valid), 32'h1);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("rr_last_valid", 32'(bus.rsp_valid), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(bus.rsp_valid), 32'h0);

    // Single request on id 2
    @(posedge clk);
    #1 bus.req_valid = 4'b0100;
    set_ops(2, 32'd5, 32'd7);
    push(32'd12, 2'd2, 1'b0);
    @(negedge clk);
    chk("single_req_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    @(posedge clk);

    // Backpressure: result held, further requests blocked
    #1 bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    set_ops(1, 32'd3, 32'd4);
    push(32'd7, 2'd1, 1'b0);
    @(negedge clk);
    chk("bp_first_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 bus.req_valid = 4'b1010;
    set_ops(1, 32'd10, 32'd20);
    set_ops(3, 32'd1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_sum_hold", bus.rsp_sum, 32'd7);
      chk("bp_id_hold", 32'(bus.rsp_id), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    push(32'd2, 2'd3, 1'b0);
    @(negedge clk);
    chk("bp_refill_ready", 32'(bus.req_ready), 32'h8);
    @(posedge clk);
    #1 bus.req_valid = 4'b0010;
    push(32'd30, 2'd1, 1'b0);
    @(negedge clk);
    chk("bp_next_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(posedge clk);

    // Overflow and wrap-around
    #1 bus.req_valid = 4'b0001;
    set_ops(0, 32'hFFFF_FFFF, 32'd2);
`ifdef ADD_ARB_SAT_EN
    push(32'hFFFF_FFFF, 2'd0, 1'b1);
`else
    push(32'd1, 2'd0, 1'b1);
`endif
    @(negedge clk);
    chk("ovf_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 4'b0010;
    set_ops(1, 32'hFFFF_FFFF, 32'd1);
`ifdef ADD_ARB_SAT_EN
    push(32'hFFFF_FFFF, 2'd1, 1'b1);
`else
    push(32'd0, 2'd1, 1'b1);
`endif
    @(negedge clk);
    chk("wrap_req_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(posedge clk);

    // Mid-operation asynchronous reset discards the held result
    #1 bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    set_ops(2, 32'd1, 32'd1);
    @(negedge clk);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("midrst_held", 32'(bus.rsp_valid), 32'h1);
    #2;
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_async_sum", bus.rsp_sum, 32'h0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_ops(0, 32'd9, 32'd9);
    push(32'd18, 2'd0, 1'b0);
    @(negedge clk);
    chk("postrst_ptr_zero", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("final_empty", 32'(bus.rsp_valid), 32'h0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
